// File: rtl/async_receive_if.sv
// async_receive_if: serial line input and received-byte outputs of the UART receiver.
`timescale 1ns/1ps
interface async_receive_if;
   logic RxD;
   logic [7:0] RxD_data;
   logic RxD_data_ready;
   logic RxD_framing_error;
   logic RxD_idle;
   logic RxD_endofpacket;
   modport master (
      output RxD,
      input RxD_data, RxD_data_ready, RxD_framing_error, RxD_idle, RxD_endofpacket
   );
   modport slave (
      input RxD,
      output RxD_data, RxD_data_ready, RxD_framing_error, RxD_idle, RxD_endofpacket
   );
endinterface

// File: rtl/async_receive.sv
// async_receive: 8N1 UART receiver with 16x oversampling, 3-sample majority filter,
// framing-error strobe and line-idle / end-of-packet detection.
`timescale 1ns/1ps
module async_receive #(
   parameter int ClkFrequency = 66666666,
   parameter int Baud = 115200,
   parameter int BaudGeneratorAccWidth = 16,
   parameter int IdleBits = 10
) (
   input logic clk,
   input logic rst_n,
   async_receive_if.slave rx
);
   localparam int W = BaudGeneratorAccWidth;
   localparam longint IncFull = ((longint'(Baud) << (W - 7)) + longint'(ClkFrequency >> 12)) / longint'(ClkFrequency >> 11);
   localparam logic [W:0] Inc = IncFull[W:0];
   localparam logic [7:0] GapMax = 8'(16 * IdleBits);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateType;
   stateType state, stateNext;
   logic [W:0] acc;
   logic tick;
   logic [1:0] sync;
   logic [2:0] filt, filtNext;
   logic bitF;
   logic [3:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift, data, gap;
   logic ready, frameErr, seen, eop;

   assign tick = acc[W];
   assign filtNext = {filt[1:0], sync[1]};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else acc <= {1'b0, acc[W-1:0]} + Inc;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync <= 2'b11;
         filt <= 3'b111;
         bitF <= 1'b1;
      end else begin
         sync <= {sync[0], rx.RxD};
         if (tick) begin
            filt <= filtNext;
            bitF <= (filtNext[0] & filtNext[1]) | (filtNext[0] & filtNext[2]) | (filtNext[1] & filtNext[2]);
         end
      end

   always_comb begin
      stateNext = state;
      if (tick)
         case (state)
            IDLE:    stateNext = bitF ? IDLE : START;
            START:   stateNext = (cnt == 4'd7) ? (bitF ? IDLE : DATA) : START;
            DATA:    stateNext = (cnt == 4'd15 && idx == 3'd7) ? STOP : DATA;
            STOP:    stateNext = (cnt == 4'd15) ? (bitF ? IDLE : BREAK) : STOP;
            BREAK:   stateNext = bitF ? IDLE : BREAK;
            default: stateNext = IDLE;
         endcase
   end

   // Leaving STOP at mid-stop-bit lets a back-to-back start bit be caught with no gap.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= 4'd0;
         idx <= 3'd0;
         shift <= 8'd0;
         data <= 8'd0;
         ready <= 1'b0;
         frameErr <= 1'b0;
         gap <= 8'd0;
         seen <= 1'b0;
         eop <= 1'b0;
      end else begin
         state <= stateNext;
         ready <= 1'b0;
         frameErr <= 1'b0;
         eop <= 1'b0;
         if (tick) begin
            cnt <= (state == IDLE || (state == START && cnt == 4'd7)) ? 4'd0 : cnt + 4'd1;
            if (state == START) idx <= 3'd0;
            if (state == DATA && cnt == 4'd15) begin
               shift <= {bitF, shift[7:1]};
               idx <= idx + 3'd1;
            end
            if (state == STOP && cnt == 4'd15) begin
               if (bitF) begin
                  data <= shift;
                  ready <= 1'b1;
                  seen <= 1'b1;
               end else frameErr <= 1'b1;
            end
            gap <= (state != IDLE || !bitF) ? 8'd0 : (gap == GapMax ? gap : gap + 8'd1);
            if (state == IDLE && bitF && gap == GapMax - 8'd1) begin
               eop <= seen;
               seen <= 1'b0;
            end
         end
      end

   assign rx.RxD_data = data;
   assign rx.RxD_data_ready = ready;
   assign rx.RxD_framing_error = frameErr;
   assign rx.RxD_idle = (gap == GapMax);
   assign rx.RxD_endofpacket = eop;
endmodule
